// File: rtl/abellek_pkg.sv
// Shared types and constants for the main-memory arbiter / burst engine.
package abellek_pkg;

    localparam int KELIME_GENISLIK = 32;

    localparam logic [3:0] WSTRB_YAZ = 4'hF;
    localparam logic [3:0] WSTRB_OKU = 4'h0;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        AKTAR = 2'd1,
        BITTI = 2'd2
    } durum_e;

endpackage

// File: rtl/abellek_hakem_rr.sv
// Combinational request selector: fixed priority (client 0 first) or
// round robin starting the search at a supplied pointer, wrapping modulo N.
module hakem_rr #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  istek_i,
    input  logic          mod_i,
    input  logic [IW-1:0] isaretci_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] index_o,
    output logic          gecerli_o
);

    int            bas;
    int            aday;
    logic [IW-1:0] aday_k;

    // Scan N candidates from the start point and keep the first requester found.
    always_comb begin
        grant_o   = '0;
        index_o   = '0;
        gecerli_o = 1'b0;
        aday      = 0;
        aday_k    = '0;
        bas       = mod_i ? int'(isaretci_i) : 0;
        for (int i = 0; i < N; i++) begin
            aday = bas + i;
            if (aday >= N) begin
                aday = aday - N;
            end
            aday_k = IW'(aday);
            if (!gecerli_o && istek_i[aday_k]) begin
                gecerli_o       = 1'b1;
                grant_o[aday_k] = 1'b1;
                index_o         = aday_k;
            end
        end
    end

endmodule

// File: rtl/abellek_hakem.sv
// Main-memory arbiter and burst engine: grants one cache client at a time and
// moves a whole block as successive 32-bit iomem transactions.
module abellek_hakem
    import abellek_pkg::*;
#(
    parameter int ISTEMCI_SAYISI = 2,
    parameter int OBEK_KELIME    = 4,
    parameter int ONCELIK_MODU   = 1
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [ISTEMCI_SAYISI-1:0]                istek_i,
    input  logic [ISTEMCI_SAYISI-1:0]                yaz_i,
    input  logic [ISTEMCI_SAYISI*32-1:0]             adres_i,
    input  logic [ISTEMCI_SAYISI*OBEK_KELIME*32-1:0] yazilacak_obek_i,
    output logic                                     musait_o,
    output logic [ISTEMCI_SAYISI-1:0]                hazir_o,
    output logic [OBEK_KELIME*32-1:0]                okunan_obek_o,
    output logic                                     iomem_valid_o,
    output logic [3:0]                               iomem_wstrb_o,
    output logic [31:0]                              iomem_addr_o,
    output logic [31:0]                              iomem_wdata_o,
    input  logic                                     iomem_ready_i,
    input  logic [31:0]                              iomem_rdata_i
);

    localparam int N  = ISTEMCI_SAYISI;
    localparam int W  = KELIME_GENISLIK;
    localparam int BW = OBEK_KELIME * W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int KW = (OBEK_KELIME > 1) ? $clog2(OBEK_KELIME) : 1;

    localparam logic [31:0]   HIZA_MASKE = 32'(OBEK_KELIME * 4 - 1);
    localparam logic [KW-1:0] SON_KELIME = KW'(OBEK_KELIME - 1);

    durum_e        durum_q, durum_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          yaz_q, yaz_d;
    logic [31:0]   base_q, base_d;
    logic [BW-1:0] wblk_q, wblk_d;
    logic [BW-1:0] rblk_q, rblk_d;
    logic [KW-1:0] k_q, k_d;
    logic          musait_q, musait_d;
    logic [N-1:0]  hazir_q, hazir_d;
    logic [BW-1:0] okunan_q, okunan_d;
    logic          valid_q, valid_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [N-1:0]  sec_grant;
    logic [IW-1:0] sec_idx;
    logic          sec_gecerli;

    hakem_rr #(
        .N  (N),
        .IW (IW)
    ) u_hakem_rr (
        .istek_i    (istek_i),
        .mod_i      (ONCELIK_MODU != 0),
        .isaretci_i (ptr_q),
        .grant_o    (sec_grant),
        .index_o    (sec_idx),
        .gecerli_o  (sec_gecerli)
    );

    // Next-state and next-output logic; outputs are precomputed so they leave registered.
    always_comb begin
        durum_d  = durum_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        yaz_d    = yaz_q;
        base_d   = base_q;
        wblk_d   = wblk_q;
        rblk_d   = rblk_q;
        k_d      = k_q;
        musait_d = musait_q;
        hazir_d  = '0;
        okunan_d = okunan_q;
        valid_d  = valid_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (durum_q)
            BOSTA: begin
                if (sec_gecerli) begin
                    grant_d  = sec_grant;
                    idx_d    = sec_idx;
                    yaz_d    = yaz_i[sec_idx];
                    base_d   = adres_i[W*sec_idx +: W] & ~HIZA_MASKE;
                    wblk_d   = yazilacak_obek_i[BW*sec_idx +: BW];
                    k_d      = '0;
                    durum_d  = AKTAR;
                    musait_d = 1'b0;
                    valid_d  = 1'b1;
                    wstrb_d  = yaz_d ? WSTRB_YAZ : WSTRB_OKU;
                    addr_d   = base_d;
                    wdata_d  = wblk_d[W-1:0];
                end
            end
            AKTAR: begin
                if (iomem_ready_i) begin
                    if (!yaz_q) begin
                        rblk_d[W*k_q +: W] = iomem_rdata_i;
                    end
                    if (k_q == SON_KELIME) begin
                        durum_d = BITTI;
                        hazir_d = grant_q;
                        valid_d = 1'b0;
                        wstrb_d = WSTRB_OKU;
                        addr_d  = '0;
                        wdata_d = '0;
                        if (!yaz_q) begin
                            okunan_d = rblk_d;
                        end
                    end else begin
                        k_d     = k_q + 1'b1;
                        addr_d  = base_q + 32'({k_d, 2'b00});
                        wdata_d = wblk_q[W*k_d +: W];
                    end
                end
            end
            BITTI: begin
                durum_d  = BOSTA;
                musait_d = 1'b1;
                ptr_d    = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
            end
            default: begin
                durum_d  = BOSTA;
                musait_d = 1'b1;
                valid_d  = 1'b0;
                wstrb_d  = WSTRB_OKU;
            end
        endcase
    end

    // State register; reset aborts any block in flight without a completion pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q  <= BOSTA;
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            yaz_q    <= 1'b0;
            base_q   <= '0;
            wblk_q   <= '0;
            rblk_q   <= '0;
            k_q      <= '0;
            musait_q <= 1'b1;
            hazir_q  <= '0;
            okunan_q <= '0;
            valid_q  <= 1'b0;
            wstrb_q  <= WSTRB_OKU;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            durum_q  <= durum_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            yaz_q    <= yaz_d;
            base_q   <= base_d;
            wblk_q   <= wblk_d;
            rblk_q   <= rblk_d;
            k_q      <= k_d;
            musait_q <= musait_d;
            hazir_q  <= hazir_d;
            okunan_q <= okunan_d;
            valid_q  <= valid_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign musait_o      = musait_q;
    assign hazir_o       = hazir_q;
    assign okunan_obek_o = okunan_q;
    assign iomem_valid_o = valid_q;
    assign iomem_wstrb_o = wstrb_q;
    assign iomem_addr_o  = addr_q;
    assign iomem_wdata_o = wdata_q;

endmodule

// File: tb/tb_abellek_hakem.sv
// Bench for abellek_hakem: a 4-client round-robin instance driven by directed and
// random block transfers against a behavioural client/memory model, plus a small
// 2-client fixed-priority instance checked for grant order.
module tb_abellek_hakem;

    localparam int N  = 4;
    localparam int K  = 4;
    localparam int BW = K * 32;

    localparam int FN  = 2;
    localparam int FK  = 2;
    localparam int FBW = FK * 32;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]    istek;
    logic [N-1:0]    yaz;
    logic [N*32-1:0] adres;
    logic [N*BW-1:0] wblk;
    logic            ready;
    logic [31:0]     rdata;
    logic            musait;
    logic [N-1:0]    hazir;
    logic [BW-1:0]   okunan;
    logic            valid;
    logic [3:0]      wstrb;
    logic [31:0]     addr;
    logic [31:0]     wdata;

    logic [FN-1:0]     fxIstek;
    logic [FN-1:0]     fxYaz;
    logic [FN*32-1:0]  fxAdres;
    logic [FN*FBW-1:0] fxWblk;
    logic              fxReady;
    logic [31:0]       fxRdata;
    logic              fxMusait;
    logic [FN-1:0]     fxHazir;
    logic [FBW-1:0]    fxOkunan;
    logic              fxValid;
    logic [3:0]        fxWstrb;
    logic [31:0]       fxAddr;
    logic [31:0]       fxWdata;

    int total = 0;
    int bad   = 0;

    // Behavioural model: per-client pending request, round-robin start point, last read block.
    logic          cReq [N];
    logic          cYaz [N];
    logic [31:0]   cAdres [N];
    logic [BW-1:0] cBlk [N];
    int            rrNext;
    logic [BW-1:0] okunanRef;

    abellek_hakem #(
        .ISTEMCI_SAYISI (N),
        .OBEK_KELIME    (K),
        .ONCELIK_MODU   (1)
    ) u_dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .istek_i          (istek),
        .yaz_i            (yaz),
        .adres_i          (adres),
        .yazilacak_obek_i (wblk),
        .musait_o         (musait),
        .hazir_o          (hazir),
        .okunan_obek_o    (okunan),
        .iomem_valid_o    (valid),
        .iomem_wstrb_o    (wstrb),
        .iomem_addr_o     (addr),
        .iomem_wdata_o    (wdata),
        .iomem_ready_i    (ready),
        .iomem_rdata_i    (rdata)
    );

    abellek_hakem #(
        .ISTEMCI_SAYISI (FN),
        .OBEK_KELIME    (FK),
        .ONCELIK_MODU   (0)
    ) u_fix (
        .clk_i            (clk),
        .rst_i            (rst),
        .istek_i          (fxIstek),
        .yaz_i            (fxYaz),
        .adres_i          (fxAdres),
        .yazilacak_obek_i (fxWblk),
        .musait_o         (fxMusait),
        .hazir_o          (fxHazir),
        .okunan_obek_o    (fxOkunan),
        .iomem_valid_o    (fxValid),
        .iomem_wstrb_o    (fxWstrb),
        .iomem_addr_o     (fxAddr),
        .iomem_wdata_o    (fxWdata),
        .iomem_ready_i    (fxReady),
        .iomem_rdata_i    (fxRdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory contents seen by reads: a scrambled function of the byte address.
    function automatic logic [31:0] memWord(input logic [31:0] a, input logic [31:0] salt);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [BW-1:0] randBlock();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int pickGrant();
        for (int i = 0; i < N; i++) begin
            if (cReq[(rrNext + i) % N]) return (rrNext + i) % N;
        end
        return 0;
    endfunction

    function automatic bit anyReq();
        for (int c = 0; c < N; c++) begin
            if (cReq[c]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic setClient(input int c, input bit dir, input logic [31:0] a, input logic [BW-1:0] b);
        cReq[c]   = 1'b1;
        cYaz[c]   = dir;
        cAdres[c] = a;
        cBlk[c]   = b;
    endtask

    // Drive the DUT client ports from the model's per-client state.
    task automatic applyStimulus();
        for (int c = 0; c < N; c++) begin
            istek[c]            = cReq[c];
            yaz[c]              = cYaz[c];
            adres[c*32 +: 32]   = cAdres[c];
            wblk[c*BW +: BW]    = cBlk[c];
        end
    endtask

    // One complete arbitration plus block transfer, starting at a negedge with the DUT idle.
    // abortAt >= 0 asserts reset once that many words have completed.
    task automatic runTransfer(input int minWait, input int maxWait, input int abortAt);
        int            g;
        int            w;
        logic [31:0]   base;
        logic [31:0]   salt;
        logic [31:0]   a;
        logic [BW-1:0] blk;
        checkOutput("idle_musait", musait, 1);
        applyStimulus();
        g    = pickGrant();
        base = cAdres[g] - (cAdres[g] % (K * 4));
        salt = $urandom;
        blk  = '0;
        @(posedge clk);
        @(negedge clk);
        adres[g*32 +: 32] = $urandom;
        wblk[g*BW +: BW]  = randBlock();
        yaz[g]            = ~yaz[g];
        for (int j = 0; j < K; j++) begin
            a = base + 32'(4 * j);
            if (j == abortAt) begin
                rst = 1'b1;
                #1;
                checkOutput("abort_valid", valid, 0);
                checkOutput("abort_hazir", hazir, 0);
                checkOutput("abort_musait", musait, 1);
                checkOutput("abort_addr", addr, 0);
                checkOutput("abort_okunan", okunan, 0);
                okunanRef = '0;
                rrNext    = 0;
                @(negedge clk);
                rst = 1'b0;
                applyStimulus();
                return;
            end
            w = int'($urandom_range(minWait, maxWait));
            for (int s = 0; s <= w; s++) begin
                ready = (s == w);
                rdata = memWord(a, salt);
                checkOutput("xfer_valid", valid, 1);
                checkOutput("xfer_addr", addr, a);
                checkOutput("xfer_wstrb", wstrb, cYaz[g] ? 4'hF : 4'h0);
                if (cYaz[g]) checkOutput("xfer_wdata", wdata, cBlk[g][32*j +: 32]);
                checkOutput("xfer_hazir", hazir, 0);
                checkOutput("xfer_musait", musait, 0);
                @(posedge clk);
                @(negedge clk);
            end
            blk[32*j +: 32] = memWord(a, salt);
        end
        ready = 1'b0;
        checkOutput("done_hazir", hazir, (1 << g));
        if (!cYaz[g]) okunanRef = blk;
        checkOutput("done_okunan", okunan, okunanRef);
        checkOutput("done_valid", valid, 0);
        cReq[g] = 1'b0;
        rrNext  = (g + 1) % N;
        applyStimulus();
        @(posedge clk);
        @(negedge clk);
        checkOutput("after_musait", musait, 1);
        checkOutput("after_hazir", hazir, 0);
    endtask

    // Directed scenarios followed by random traffic, then fixed-priority checks.
    initial begin
        int served;
        logic [FN-1:0] fxExp [5];
        rst       = 1'b1;
        ready     = 1'b0;
        rdata     = '0;
        rrNext    = 0;
        okunanRef = '0;
        for (int c = 0; c < N; c++) begin
            cReq[c] = 1'b0; cYaz[c] = 1'b0; cAdres[c] = '0; cBlk[c] = '0;
        end
        applyStimulus();
        fxIstek = '0; fxYaz = '0; fxAdres = '0; fxWblk = '0; fxReady = 1'b1; fxRdata = 32'hCAFE_0001;
        #12;
        checkOutput("rst_musait", musait, 1);
        checkOutput("rst_hazir", hazir, 0);
        checkOutput("rst_okunan", okunan, 0);
        checkOutput("rst_valid", valid, 0);
        checkOutput("rst_wstrb", wstrb, 0);
        checkOutput("rst_addr", addr, 0);
        checkOutput("rst_wdata", wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_ready_valid", valid, 0);
        checkOutput("idle_ready_hazir", hazir, 0);
        ready = 1'b0;

        $display("[TB] single read, client 0");
        setClient(0, 1'b0, 32'h0000_1234, randBlock());
        runTransfer(0, 0, -1);

        $display("[TB] write-back, client 1, two wait states");
        setClient(1, 1'b1, 32'h0000_2000, {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000});
        runTransfer(2, 2, -1);

        $display("[TB] round robin alternation, clients 0 and 1");
        for (int t = 0; t < 4; t++) begin
            if (!cReq[0]) setClient(0, 1'($urandom_range(0, 1)), $urandom, randBlock());
            if (!cReq[1]) setClient(1, 1'($urandom_range(0, 1)), $urandom, randBlock());
            runTransfer(0, 1, -1);
        end
        cReq[0] = 1'b0;
        cReq[1] = 1'b0;
        applyStimulus();

        $display("[TB] wrap-around after client 3");
        setClient(3, 1'b0, $urandom, randBlock());
        runTransfer(0, 1, -1);
        setClient(3, 1'b0, $urandom, randBlock());
        setClient(1, 1'b0, $urandom, randBlock());
        runTransfer(0, 1, -1);
        runTransfer(0, 1, -1);

        $display("[TB] reset during word 2 of a read");
        setClient(2, 1'b0, $urandom, randBlock());
        runTransfer(0, 1, -1);
        setClient(1, 1'b0, $urandom, randBlock());
        runTransfer(0, 2, 2);
        setClient(3, 1'b1, $urandom, randBlock());
        runTransfer(0, 1, -1);
        runTransfer(0, 1, -1);

        $display("[TB] random traffic");
        for (int t = 0; t < 30; t++) begin
            for (int c = 0; c < N; c++) begin
                if (!cReq[c] && $urandom_range(0, 1) == 1)
                    setClient(c, 1'($urandom_range(0, 1)), $urandom, randBlock());
            end
            if (!anyReq())
                setClient(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), $urandom, randBlock());
            runTransfer(0, 3, -1);
        end

        $display("[TB] fixed priority instance");
        fxExp[0] = 2'b01; fxExp[1] = 2'b01; fxExp[2] = 2'b01; fxExp[3] = 2'b10; fxExp[4] = 2'b01;
        served  = 0;
        fxIstek = 2'b11;
        for (int cyc = 0; cyc < 60 && served < 5; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (fxHazir != '0) begin
                checkOutput("fix_grant", fxHazir, fxExp[served]);
                served++;
                if (served == 3) fxIstek = 2'b10;
                if (served == 4) fxIstek = 2'b11;
            end
        end
        checkOutput("fix_served_count", served, 5);
        fxIstek = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
